rect_slide_generator: RTL and testbench

- Producer side of the rectangle coordinate bus consumed by the VGA rectangle display.
- Generates pseudo-random red and blue rectangle corner coordinates with an LFSR.
- Commits a new "slide" only at the last pixel of a frame, every FRAMES_PER_SLIDE frames, so the display never tears.
- Sits between the VGA timing counters (pixel_out/line_out) and the display block.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/lfsr16.sv | 23 ++
 rtl/rect_slide_generator.sv | 151 +++++++++++++++
 tb/tb_rect_slide_generator.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Constants, FSM encoding and LFSR step shared by the VGA timing, display
// and rectangle generator blocks.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_LAST    = 799;
    localparam int V_LAST    = 524;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic { GEN = 1'b0, READY = 1'b1 } slide_state_e;

    typedef struct packed {
        logic [9:0] w0;
        logic [9:0] w1;
        logic [8:0] h0;
        logic [8:0] h1;
    } rect_t;

    typedef struct packed {
        rect_t red;
        rect_t blue;
    } slide_t;

    // Galois right-shift step; the tap mask is applied when bit 0 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with a loadable seed; an all-zero seed would lock up,
// so it is replaced by 1.
module lfsr16
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic [15:0] value_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (step) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign value = value_q;
endmodule

// File: rtl/rect_slide_generator.sv
// Builds the next red/blue rectangle pair in shadow registers and commits it
// to the display outputs only on the last pixel of a slide-ending frame.
//
//   state | meaning
//   GEN   | 8 cycles, one LFSR step per cycle fills shadow edge gen_idx
//   READY | shadow complete, waiting for the slide boundary to commit
module rect_slide_generator #(
    parameter int          H_VISIBLE        = vga_pkg::H_VISIBLE,
    parameter int          V_VISIBLE        = vga_pkg::V_VISIBLE,
    parameter int          H_LAST           = vga_pkg::H_LAST,
    parameter int          V_LAST           = vga_pkg::V_LAST,
    parameter int          FRAMES_PER_SLIDE = 60,
    parameter logic [15:0] SEED             = 16'hACE1,
    parameter int          MIN_SIZE         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [9:0]  pixel_out,
    input  logic [9:0]  line_out,
    output logic [9:0]  rw0_out,
    output logic [9:0]  rw1_out,
    output logic [8:0]  rh0_out,
    output logic [8:0]  rh1_out,
    output logic [9:0]  bw0_out,
    output logic [9:0]  bw1_out,
    output logic [8:0]  bh0_out,
    output logic [8:0]  bh1_out,
    output logic        slide_tick,
    output logic [15:0] slide_count
);
    import vga_pkg::*;

    localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_SLIDE - 1);
    localparam logic [9:0]  W_LIMIT    = 10'(H_VISIBLE);
    localparam logic [9:0]  H_LIMIT    = 10'(V_VISIBLE);
    localparam logic [9:0]  W_HALF     = 10'(H_VISIBLE / 2);
    localparam logic [9:0]  H_HALF     = 10'(V_VISIBLE / 2);
    localparam logic [9:0]  MIN_EDGE   = 10'(MIN_SIZE);

    slide_state_e state_q;
    logic [2:0]   gen_idx_q;
    logic [15:0]  frame_cnt_q;
    logic [15:0]  slide_count_q;
    logic         slide_tick_q;
    slide_t       shadow_q;
    slide_t       out_q;

    logic [15:0] lfsr_val;
    logic        eof;
    logic        boundary;
    logic [9:0]  gen_src;
    logic [9:0]  gen_raw;
    logic [9:0]  gen_first;
    logic [9:0]  gen_limit;
    logic [9:0]  gen_half;
    logic        gen_near;
    logic [9:0]  gen_d;

    assign eof      = (pixel_out == 10'(H_LAST)) && (line_out == 10'(V_LAST));
    assign boundary = en && eof && (frame_cnt_q == FRAME_LAST);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state_q == GEN),
        .seed  (SEED),
        .value (lfsr_val)
    );

    // Odd indices are the second edge of a pair and are pushed MIN_SIZE away
    // from the first edge when the two would be less than 2 apart.
    always_comb begin
        gen_src   = 10'(lfsr_next(lfsr_val));
        gen_limit = gen_idx_q[1] ? H_LIMIT : W_LIMIT;
        gen_half  = gen_idx_q[1] ? H_HALF : W_HALF;
        gen_raw   = gen_idx_q[1] ? {1'b0, gen_src[8:0]} : gen_src;
        if (gen_raw >= gen_limit) begin
            gen_raw = gen_raw - gen_limit;
        end
        case (gen_idx_q[2:1])
            2'd0:    gen_first = shadow_q.red.w0;
            2'd1:    gen_first = {1'b0, shadow_q.red.h0};
            2'd2:    gen_first = shadow_q.blue.w0;
            default: gen_first = {1'b0, shadow_q.blue.h0};
        endcase
        gen_near = ({1'b0, gen_raw} <= {1'b0, gen_first} + 11'd1) &&
                   ({1'b0, gen_first} <= {1'b0, gen_raw} + 11'd1);
        if (gen_idx_q[0] && gen_near) begin
            gen_d = (gen_first < gen_half) ? gen_first + MIN_EDGE : gen_first - MIN_EDGE;
        end else begin
            gen_d = gen_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= GEN;
            gen_idx_q     <= 3'd0;
            frame_cnt_q   <= 16'd0;
            slide_count_q <= 16'd0;
            slide_tick_q  <= 1'b0;
            shadow_q      <= '0;
            out_q         <= '0;
        end else begin
            slide_tick_q <= 1'b0;
            if (en && eof) begin
                frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? 16'd0 : frame_cnt_q + 16'd1;
            end
            case (state_q)
                GEN: begin
                    case (gen_idx_q)
                        3'd0: shadow_q.red.w0  <= gen_d;
                        3'd1: shadow_q.red.w1  <= gen_d;
                        3'd2: shadow_q.red.h0  <= gen_d[8:0];
                        3'd3: shadow_q.red.h1  <= gen_d[8:0];
                        3'd4: shadow_q.blue.w0 <= gen_d;
                        3'd5: shadow_q.blue.w1 <= gen_d;
                        3'd6: shadow_q.blue.h0 <= gen_d[8:0];
                        3'd7: shadow_q.blue.h1 <= gen_d[8:0];
                    endcase
                    gen_idx_q <= gen_idx_q + 3'd1;
                    if (gen_idx_q == 3'd7) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (boundary) begin
                        out_q         <= shadow_q;
                        slide_tick_q  <= 1'b1;
                        slide_count_q <= slide_count_q + 16'd1;
                        gen_idx_q     <= 3'd0;
                        state_q       <= GEN;
                    end
                end
                default: state_q <= GEN;
            endcase
        end
    end

    assign rw0_out     = out_q.red.w0;
    assign rw1_out     = out_q.red.w1;
    assign rh0_out     = out_q.red.h0;
    assign rh1_out     = out_q.red.h1;
    assign bw0_out     = out_q.blue.w0;
    assign bw1_out     = out_q.blue.w1;
    assign bh0_out     = out_q.blue.h0;
    assign bh1_out     = out_q.blue.h1;
    assign slide_tick  = slide_tick_q;
    assign slide_count = slide_count_q;
endmodule

// File: tb/tb_rect_slide_generator.sv
// Directed bench for rect_slide_generator with a two-frame slide and a
// shortened frame so commits come quickly.
module tb_rect_slide_generator;
    localparam int FPS = 2;
    localparam int HL  = 9;
    localparam int VL  = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [9:0] p_in  = 10'd0;
    logic [9:0] l_in  = 10'd0;

    logic [9:0]  rw0, rw1, bw0, bw1;
    logic [8:0]  rh0, rh1, bh0, bh1;
    logic        tick;
    logic [15:0] count;

    logic [9:0]  lo_rw0, lo_rw1, lo_bw0, lo_bw1;
    logic [8:0]  lo_rh0, lo_rh1, lo_bh0, lo_bh1;
    logic        lo_tick;
    logic [15:0] lo_count;

    logic [9:0]  hi_rw0, hi_rw1, hi_bw0, hi_bw1;
    logic [8:0]  hi_rh0, hi_rh1, hi_bh0, hi_bh1;
    logic        hi_tick;
    logic [15:0] hi_count;

    rect_slide_generator #(.H_LAST(HL), .V_LAST(VL), .FRAMES_PER_SLIDE(FPS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_out(p_in), .line_out(l_in),
        .rw0_out(rw0), .rw1_out(rw1), .rh0_out(rh0), .rh1_out(rh1),
        .bw0_out(bw0), .bw1_out(bw1), .bh0_out(bh0), .bh1_out(bh1),
        .slide_tick(tick), .slide_count(count));

    rect_slide_generator #(.H_LAST(HL), .V_LAST(VL), .FRAMES_PER_SLIDE(FPS),
                           .SEED(16'h1000)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_out(p_in), .line_out(l_in),
        .rw0_out(lo_rw0), .rw1_out(lo_rw1), .rh0_out(lo_rh0), .rh1_out(lo_rh1),
        .bw0_out(lo_bw0), .bw1_out(lo_bw1), .bh0_out(lo_bh0), .bh1_out(lo_bh1),
        .slide_tick(lo_tick), .slide_count(lo_count));

    rect_slide_generator #(.H_LAST(HL), .V_LAST(VL), .FRAMES_PER_SLIDE(FPS),
                           .SEED(16'h0FFE)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_out(p_in), .line_out(l_in),
        .rw0_out(hi_rw0), .rw1_out(hi_rw1), .rh0_out(hi_rh0), .rh1_out(hi_rh1),
        .bw0_out(hi_bw0), .bw1_out(hi_bw1), .bh0_out(hi_bh0), .bh1_out(hi_bh1),
        .slide_tick(hi_tick), .slide_count(hi_count));

    always #5 clk = ~clk;

    logic [9:0] obs [8];
    assign obs[0] = rw0;
    assign obs[1] = rw1;
    assign obs[2] = {1'b0, rh0};
    assign obs[3] = {1'b0, rh1};
    assign obs[4] = bw0;
    assign obs[5] = bw1;
    assign obs[6] = {1'b0, bh0};
    assign obs[7] = {1'b0, bh1};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: expected next slide and the slide currently on display.
    logic [15:0] m_lfsr;
    logic [9:0]  m_exp  [8];
    logic [9:0]  m_prev [8];

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_gen();
        int v, lim, f;
        for (int i = 0; i < 8; i++) begin
            m_prev[i] = m_exp[i];
            m_lfsr = m_step(m_lfsr);
            if ((i % 4) >= 2) begin
                lim = 480;
                v = int'(m_lfsr[8:0]);
            end else begin
                lim = 640;
                v = int'(m_lfsr[9:0]);
            end
            if (v >= lim) v = v - lim;
            if ((i % 2) == 1) begin
                f = int'(m_exp[i-1]);
                if ((v - f) < 2 && (f - v) < 2) v = (f < lim / 2) ? f + 16 : f - 16;
            end
            m_exp[i] = 10'(v);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 8; i++) m_exp[i] = 10'd0;
        model_gen();
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int len);
        p_in = 10'd0;
        l_in = 10'd0;
        repeat (len) step_clk();
        p_in = 10'(HL);
        l_in = 10'(VL);
        step_clk();
        p_in = 10'd0;
        l_in = 10'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        p_in  = 10'd0;
        l_in  = 10'd0;
        repeat (3) step_clk();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        p_in  = 10'd0;
        l_in  = 10'd0;
        repeat (3) step_clk();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_out[%0d]: got %0d expected 0", i, obs[i]);
            end
        end
        n_cmp++;
        if (count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got %0d expected 0", tick);
        end
        // Boundary on the 8th cycle after release lands in the last GEN cycle.
        rst_n = 1'b1;
        p_in = 10'(HL); l_in = 10'(VL);
        step_clk();
        p_in = 10'd0; l_in = 10'd0;
        repeat (6) step_clk();
        p_in = 10'(HL); l_in = 10'(VL);
        step_clk();
        p_in = 10'd0; l_in = 10'd0;
        n_cmp++;
        if (count !== 16'd0) begin
            n_bad++;
            $display("FAIL commit_during_gen count: got %0d expected 0", count);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_bad++;
            $display("FAIL commit_during_gen tick: got %0d expected 0", tick);
        end
        // Boundary on the 9th cycle finds READY and commits.
        do_reset();
        p_in = 10'(HL); l_in = 10'(VL);
        step_clk();
        p_in = 10'd0; l_in = 10'd0;
        repeat (7) step_clk();
        p_in = 10'(HL); l_in = 10'(VL);
        step_clk();
        p_in = 10'd0; l_in = 10'd0;
        n_cmp++;
        if (tick !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_8 tick: got %0d expected 1", tick);
        end
        n_cmp++;
        if (count !== 16'd1) begin
            n_bad++;
            $display("FAIL ready_after_8 count: got %0d expected 1", count);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== m_exp[i]) begin
                n_bad++;
                $display("FAIL ready_after_8 out[%0d]: got %0d expected %0d", i, obs[i], m_exp[i]);
            end
        end
    endtask

    task automatic test_commit_timing();
        do_reset();
        frame(10);
        n_cmp++;
        if (count !== 16'd0 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL first_eof_no_commit: count %0d tick %0d expected 0 0", count, tick);
        end
        frame(10);
        n_cmp++;
        if (tick !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_tick: got %0d expected 1", tick);
        end
        step_clk();
        n_cmp++;
        if (tick !== 1'b0) begin
            n_bad++;
            $display("FAIL tick_one_cycle: got %0d expected 0", tick);
        end
        for (int s = 1; s <= 20; s++) begin
            if (s > 1) begin
                frame(10);
                frame(10);
            end
            n_cmp++;
            if (count !== 16'(s)) begin
                n_bad++;
                $display("FAIL slide_count: got %0d expected %0d", count, s);
            end
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (obs[i] !== m_exp[i]) begin
                    n_bad++;
                    $display("FAIL slide %0d out[%0d]: got %0d expected %0d", s, i, obs[i], m_exp[i]);
                end
            end
            model_gen();
        end
    endtask

    task automatic test_range();
        bit ok;
        bit same;
        int d;
        for (int k = 0; k < 1000; k++) begin
            frame(4);
            frame(4);
            ok = (obs[0] < 10'd640) && (obs[1] < 10'd640) && (obs[4] < 10'd640) &&
                 (obs[5] < 10'd640) && (obs[2] < 10'd480) && (obs[3] < 10'd480) &&
                 (obs[6] < 10'd480) && (obs[7] < 10'd480);
            for (int p = 0; p < 4; p++) begin
                d = int'(obs[2*p]) - int'(obs[2*p+1]);
                if (d < 2 && d > -2) ok = 1'b0;
            end
            n_cmp++;
            if (ok !== 1'b1) begin
                n_bad++;
                $display("FAIL range slide %0d: %0d %0d %0d %0d %0d %0d %0d %0d", k + 21,
                         obs[0], obs[1], obs[2], obs[3], obs[4], obs[5], obs[6], obs[7]);
            end
            same = 1'b1;
            for (int i = 0; i < 8; i++) if (obs[i] !== m_exp[i]) same = 1'b0;
            n_cmp++;
            if (same !== 1'b1) begin
                n_bad++;
                $display("FAIL model slide %0d: got rw0 %0d rw1 %0d expected %0d %0d", k + 21,
                         obs[0], obs[1], m_exp[0], m_exp[1]);
            end
            model_gen();
        end
        n_cmp++;
        if (count !== 16'd1020) begin
            n_bad++;
            $display("FAIL range_count: got %0d expected 1020", count);
        end
    endtask

    task automatic test_en_gating();
        frame(10);
        n_cmp++;
        if (count !== 16'd1020) begin
            n_bad++;
            $display("FAIL pre_gate count: got %0d expected 1020", count);
        end
        en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame(10);
            n_cmp++;
            if (count !== 16'd1020 || tick !== 1'b0) begin
                n_bad++;
                $display("FAIL gated frame %0d: count %0d tick %0d expected 1020 0", f, count, tick);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== m_prev[i]) begin
                n_bad++;
                $display("FAIL gated_hold out[%0d]: got %0d expected %0d", i, obs[i], m_prev[i]);
            end
        end
        en = 1'b1;
        frame(10);
        n_cmp++;
        if (count !== 16'd1021 || tick !== 1'b1) begin
            n_bad++;
            $display("FAIL resume: count %0d tick %0d expected 1021 1", count, tick);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== m_exp[i]) begin
                n_bad++;
                $display("FAIL resume out[%0d]: got %0d expected %0d", i, obs[i], m_exp[i]);
            end
        end
        model_gen();
    endtask

    task automatic test_reset_mid_gen();
        repeat (4) step_clk();
        rst_n = 1'b0;
        step_clk();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== 10'd0) begin
                n_bad++;
                $display("FAIL midgen_reset out[%0d]: got %0d expected 0", i, obs[i]);
            end
        end
        n_cmp++;
        if (count !== 16'd0 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL midgen_reset: count %0d tick %0d expected 0 0", count, tick);
        end
        do_reset();
        frame(10);
        frame(10);
        n_cmp++;
        if (count !== 16'd1) begin
            n_bad++;
            $display("FAIL midgen_first count: got %0d expected 1", count);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== m_exp[i]) begin
                n_bad++;
                $display("FAIL midgen_first out[%0d]: got %0d expected %0d", i, obs[i], m_exp[i]);
            end
        end
    endtask

    // Seed 0x1000 yields rw0 = rw1 = 0; seed 0x0FFE yields rw0 = rw1 = 383.
    task automatic test_degeneracy();
        do_reset();
        frame(10);
        frame(10);
        n_cmp++;
        if (lo_rw0 !== 10'd0) begin
            n_bad++;
            $display("FAIL degen_lo rw0: got %0d expected 0", lo_rw0);
        end
        n_cmp++;
        if (lo_rw1 !== 10'd16) begin
            n_bad++;
            $display("FAIL degen_lo rw1: got %0d expected 16", lo_rw1);
        end
        n_cmp++;
        if (hi_rw0 !== 10'd383) begin
            n_bad++;
            $display("FAIL degen_hi rw0: got %0d expected 383", hi_rw0);
        end
        n_cmp++;
        if (hi_rw1 !== 10'd367) begin
            n_bad++;
            $display("FAIL degen_hi rw1: got %0d expected 367", hi_rw1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_commit_timing();
        test_range();
        test_en_gating();
        test_reset_mid_gen();
        test_degeneracy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
